// File: rtl/mdio_master_ctrl.sv
// MDIO (clause 22) management master: serialises one read or write frame
// per accepted request onto mdc/mdo/mdoEn and returns read data and a
// turnaround error flag.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// PRE   | driving the all-ones preamble
// HDR   | driving ST, OP, PHY address and register address
// TA    | turnaround: 1,0 for writes, released for reads
// DATA  | 16 data bits, driven for writes, sampled for reads
// DONE  | one-cycle completion, rsp_valid=1
module mdio_master_ctrl #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdoEn,
  input  logic        mdi
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

  // Down-counters: div_q counts the cycles of one mdc half-period,
  // bit_q counts the bits remaining in the current field.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;
  localparam logic [5:0] HDR_LAST = 6'd13;
  localparam logic [5:0] TA_LAST  = 6'd1;
  localparam logic [5:0] DAT_LAST = 6'd15;

  state_t      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        mdo_en_q, mdo_en_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        wr_q, wr_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  regad_q, regad_d;
  // Holds write data for writes; reused as the receive shift register for reads.
  logic [15:0] data_q, data_d;
  logic        ta_err_q, ta_err_d;
  logic [1:0]  sync_q, sync_d;

  logic        accept;
  logic        bit_end;
  logic        start_bit;
  logic        mdi_s;
  logic [13:0] hdr;

  // Next-state, bit sequencing and registered output values.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    div_d       = div_q;
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    mdo_en_d    = mdo_en_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_d        = wr_q;
    phy_d       = phy_q;
    regad_d     = regad_q;
    data_d      = data_q;
    ta_err_d    = ta_err_q;
    sync_d      = {sync_q[0], mdi};
    mdi_s       = sync_q[1];
    accept      = 1'b0;
    bit_end     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          accept  = 1'b1;
          wr_d    = req_write;
          phy_d   = req_phy;
          regad_d = req_reg;
          data_d  = req_wdata;
          mdc_d   = 1'b0;
          div_d   = DIV_LAST;
          if (PREAMBLE_LEN > 0) begin
            state_d = PRE;
            bit_d   = PRE_LAST;
          end else begin
            state_d = HDR;
            bit_d   = HDR_LAST;
          end
        end
      end
      PRE, HDR, TA, DATA: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d   = DIV_LAST;
          mdc_d   = ~mdc_q;
          bit_end = mdc_q;
        end
        // Bit end is the last cycle of the mdc high phase: sample and advance.
        if (bit_end) begin
          if (!wr_q && state_q == TA && bit_q == 6'd0) ta_err_d = mdi_s;
          if (!wr_q && state_q == DATA) data_d = {data_q[14:0], mdi_s};
          if (bit_q != 6'd0) begin
            bit_d = bit_q - 6'd1;
          end else begin
            case (state_q)
              PRE: begin
                state_d = HDR;
                bit_d   = HDR_LAST;
              end
              HDR: begin
                state_d = TA;
                bit_d   = TA_LAST;
              end
              TA: begin
                state_d = DATA;
                bit_d   = DAT_LAST;
              end
              default: begin
                state_d     = DONE;
                bit_d       = 6'd0;
                div_d       = 8'd0;
                rsp_valid_d = 1'b1;
                if (wr_q) begin
                  rsp_err_d = 1'b0;
                end else begin
                  rsp_err_d   = ta_err_q;
                  rsp_rdata_d = data_d;
                end
              end
            endcase
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // mdo/mdoEn change only when a new bit period begins.
    start_bit = accept || (bit_end && state_d != DONE);
    hdr       = {2'b01, (wr_d ? 2'b01 : 2'b10), phy_d, regad_d};
    if (start_bit) begin
      case (state_d)
        HDR: begin
          mdo_en_d = 1'b1;
          mdo_d    = hdr[bit_d[3:0]];
        end
        TA: begin
          mdo_en_d = wr_d;
          mdo_d    = wr_d ? bit_d[0] : 1'b1;
        end
        DATA: begin
          mdo_en_d = wr_d;
          mdo_d    = wr_d ? data_d[bit_d[3:0]] : 1'b1;
        end
        default: begin
          mdo_en_d = 1'b1;
          mdo_d    = 1'b1;
        end
      endcase
    end else if (state_d == IDLE || state_d == DONE) begin
      mdo_en_d = 1'b0;
      mdo_d    = 1'b1;
    end

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_q       <= 6'd0;
      div_q       <= 8'd0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      mdo_en_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'd0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      phy_q       <= 5'd0;
      regad_q     <= 5'd0;
      data_q      <= 16'd0;
      ta_err_q    <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      mdo_en_q    <= mdo_en_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_q        <= wr_d;
      phy_q       <= phy_d;
      regad_q     <= regad_d;
      data_q      <= data_d;
      ta_err_q    <= ta_err_d;
      sync_q      <= sync_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdo       = mdo_q;
  assign mdoEn     = mdo_en_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Bench for mdio_master_ctrl: two instances (CLK_DIV=2/PREAMBLE_LEN=32 and
// CLK_DIV=5/PREAMBLE_LEN=0), a PHY model on mdi, and a frame-level
// reference model built from the clause-22 frame format.
module tb_mdio_master_ctrl;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic              req_write;
  logic [4:0]        req_phy;
  logic [4:0]        req_reg;
  logic [15:0]       req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0][15:0]  rsp_rdata;
  logic [1:0]        rsp_err;
  logic [1:0]        mdc;
  logic [1:0]        mdo;
  logic [1:0]        mdo_en;
  logic              mdi;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_rd [2];

  mdio_master_ctrl #(.CLK_DIV(2), .PREAMBLE_LEN(32)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .mdc(mdc[0]), .mdo(mdo[0]), .mdoEn(mdo_en[0]), .mdi(mdi));

  mdio_master_ctrl #(.CLK_DIV(5), .PREAMBLE_LEN(0)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .mdc(mdc[1]), .mdo(mdo[1]), .mdoEn(mdo_en[1]), .mdi(mdi));

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    bit          present;
    logic [15:0] rv;
    logic [15:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  function automatic int pre_of(input int d);
    return (d == 0) ? 32 : 0;
  endfunction

  // Presents a request and returns one cycle after the accepting edge.
  task automatic issue(input int d, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                       input logic [15:0] wd, input bit keep, output int waited);
    int w = 0;
    while (req_ready[d] !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    check($sformatf("ready_wait_dut%0d", d), (w < 2000), 1);
    waited    = w;
    req_write = wr;
    req_phy   = phy;
    req_reg   = rg;
    req_wdata = wd;
    req_valid[d] = 1'b1;
    step();
    if (!keep) req_valid[d] = 1'b0;
    req_write = 1'($urandom);
    req_phy   = 5'($urandom);
    req_reg   = 5'($urandom);
    req_wdata = 16'($urandom);
  endtask

  // Follows one accepted frame cycle by cycle, playing the PHY on mdi.
  task automatic monitor(input int d, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] wd, input bit present, input logic [15:0] rv,
                         input string tag, output logic [15:0] rd, output logic er);
    int D   = div_of(d);
    int P   = pre_of(d);
    int N   = P + 32;
    int per = 2 * D;
    int lat = 1 + per * N;
    bit eb[$];
    bit ee[$];
    int s_err = 0, m_err = 0, r_err = 0, rv_k = -1, rv_n = 0, rises = 0, first_off = -1;
    logic prev_mdc = 1'b0;
    rd = 16'hxxxx;
    er = 1'bx;
    for (int j = 0; j < P; j++) begin eb.push_back(1'b1); ee.push_back(1'b1); end
    eb.push_back(1'b0); ee.push_back(1'b1);
    eb.push_back(1'b1); ee.push_back(1'b1);
    eb.push_back(!wr);  ee.push_back(1'b1);
    eb.push_back(wr);   ee.push_back(1'b1);
    for (int b = 4; b >= 0; b--) begin eb.push_back(phy[b]); ee.push_back(1'b1); end
    for (int b = 4; b >= 0; b--) begin eb.push_back(rg[b]); ee.push_back(1'b1); end
    if (wr) begin
      eb.push_back(1'b1); ee.push_back(1'b1);
      eb.push_back(1'b0); ee.push_back(1'b1);
      for (int b = 15; b >= 0; b--) begin eb.push_back(wd[b]); ee.push_back(1'b1); end
    end else begin
      for (int b = 0; b < 18; b++) begin eb.push_back(1'b1); ee.push_back(1'b0); end
    end
    for (int k = 1; k <= lat; k++) begin
      int i  = (k - 1) / per;
      int ph = (k - 1) % per;
      if (k < lat) begin
        if (ph == 0) begin
          if (!wr && i == P + 15) mdi = present ? 1'b0 : 1'b1;
          else if (!wr && i >= P + 16) mdi = present ? rv[15 - (i - P - 16)] : 1'b1;
          else mdi = 1'b1;
          if (mdo_en[d] === 1'b0 && first_off < 0) first_off = i;
        end
        if (mdo[d] !== eb[i] || mdo_en[d] !== ee[i]) s_err++;
        if (mdc[d] !== ((ph >= D) ? 1'b1 : 1'b0)) m_err++;
        if (mdc[d] === 1'b1 && prev_mdc === 1'b0) rises++;
      end else if (mdc[d] !== 1'b0) begin
        m_err++;
      end
      prev_mdc = mdc[d];
      if (req_ready[d] !== 1'b0) r_err++;
      if (rsp_valid[d] === 1'b1) begin
        rv_n++;
        if (rv_k < 0) rv_k = k;
      end
      if (k == lat) begin
        rd = rsp_rdata[d];
        er = rsp_err[d];
      end
      step();
    end
    mdi = 1'b1;
    check({tag, " stream_mismatches"}, s_err, 0);
    check({tag, " mdc_shape_mismatches"}, m_err, 0);
    check({tag, " mdc_rising_edges"}, rises, N);
    check({tag, " ready_during_frame"}, r_err, 0);
    check({tag, " rsp_valid_cycle"}, rv_k, lat);
    check({tag, " rsp_valid_pulses"}, rv_n, 1);
    check({tag, " ready_after"}, req_ready[d], 1'b1);
    check({tag, " mdc_after"}, mdc[d], 1'b0);
    check({tag, " mdoen_after"}, mdo_en[d], 1'b0);
    if (!wr) check({tag, " mdoen_fall_bit"}, first_off, P + 14);
  endtask

  task automatic run(input int d, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                     input logic [15:0] wd, input bit present, input logic [15:0] rv,
                     input bit keep, input string tag,
                     output logic [15:0] rd, output logic er, output int waited);
    issue(d, wr, phy, rg, wd, keep, waited);
    monitor(d, wr, phy, rg, wd, present, rv, tag, rd, er);
  endtask

  // Reference response: reads return the PHY word (all ones if nobody drives),
  // writes keep the previous read data and clear the error flag.
  task automatic expect_rsp(input int d, input bit wr, input bit present, input logic [15:0] rv,
                            input logic [15:0] rd, input logic er, input string tag);
    logic [15:0] exp_rd;
    logic        exp_er;
    if (wr) begin
      exp_rd = last_rd[d];
      exp_er = 1'b0;
    end else begin
      exp_rd = present ? rv : 16'hFFFF;
      exp_er = !present;
    end
    last_rd[d] = exp_rd;
    check({tag, " rsp_rdata"}, rd, exp_rd);
    check({tag, " rsp_err"}, er, exp_er);
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          w;
    int          pulses;

    tbl[0] = '{1'b1, 5'd1,  5'd0,  16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 5'd3,  5'd2,  16'h0000, 1'b1, 16'h0022, 16'h0022, 1'b0};
    tbl[2] = '{1'b1, 5'd31, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 16'h0022, 1'b0};
    tbl[3] = '{1'b0, 5'd7,  5'd1,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b1, 5'd16, 5'd9,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
    tbl[5] = '{1'b0, 5'd21, 5'd30, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0};

    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 1'b0;
    req_phy   = 5'd0;
    req_reg   = 5'd0;
    req_wdata = 16'd0;
    mdi       = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ready_dut%0d", d), req_ready[d], 1'b1);
      check($sformatf("reset_mdc_dut%0d", d), mdc[d], 1'b0);
      check($sformatf("reset_mdo_dut%0d", d), mdo[d], 1'b1);
      check($sformatf("reset_mdoen_dut%0d", d), mdo_en[d], 1'b0);
      check($sformatf("reset_rsp_valid_dut%0d", d), rsp_valid[d], 1'b0);
      check($sformatf("reset_rdata_dut%0d", d), rsp_rdata[d], 16'h0000);
      check($sformatf("reset_err_dut%0d", d), rsp_err[d], 1'b0);
      last_rd[d] = 16'h0000;
    end
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      run(0, tbl[v].wr, tbl[v].phy, tbl[v].rg, tbl[v].wd, tbl[v].present, tbl[v].rv, 1'b0,
          $sformatf("vec%0d", v), rd, er, w);
      check($sformatf("vec%0d rsp_rdata", v), rd, tbl[v].exp_rd);
      check($sformatf("vec%0d rsp_err", v), er, tbl[v].exp_er);
      last_rd[0] = tbl[v].exp_rd;
    end

    // Back-to-back with req_valid held high across both frames.
    run(0, 1'b1, 5'd4, 5'd5, 16'h3C5A, 1'b0, 16'h0000, 1'b1, "b2b_a", rd, er, w);
    expect_rsp(0, 1'b1, 1'b0, 16'h0000, rd, er, "b2b_a");
    run(0, 1'b0, 5'd6, 5'd7, 16'h0000, 1'b1, 16'h8001, 1'b0, "b2b_b", rd, er, w);
    check("b2b_second_accept_wait", w, 0);
    expect_rsp(0, 1'b0, 1'b1, 16'h8001, rd, er, "b2b_b");

    // Reset in the middle of the DATA field of a write.
    issue(0, 1'b1, 5'd2, 5'd3, 16'hAAAA, 1'b0, w);
    repeat (208) step();
    check("midreset_in_frame_mdoen", mdo_en[0], 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_mdc", mdc[0], 1'b0);
    check("midreset_mdoen", mdo_en[0], 1'b0);
    check("midreset_mdo", mdo[0], 1'b1);
    check("midreset_ready", req_ready[0], 1'b1);
    pulses = 0;
    for (int c = 0; c < 400; c++) begin
      if (rsp_valid[0] === 1'b1) pulses++;
      step();
    end
    check("midreset_rsp_valid_pulses", pulses, 0);
    check("midreset_rdata", rsp_rdata[0], 16'h0000);
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;

    // Clock shape and latency with CLK_DIV=5, no preamble.
    run(1, 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000, 1'b0, "cd5_wr", rd, er, w);
    expect_rsp(1, 1'b1, 1'b0, 16'h0000, rd, er, "cd5_wr");
    run(1, 1'b0, 5'd3, 5'd2, 16'h0000, 1'b1, 16'h0022, 1'b0, "cd5_rd", rd, er, w);
    expect_rsp(1, 1'b0, 1'b1, 16'h0022, rd, er, "cd5_rd");

    for (int r = 0; r < 12; r++) begin
      int          d  = r % 2;
      bit          wr = 1'($urandom);
      logic [4:0]  ph = 5'($urandom);
      logic [4:0]  rg = 5'($urandom);
      logic [15:0] wd = 16'($urandom);
      bit          pr = ($urandom_range(0, 3) != 0);
      logic [15:0] rv = 16'($urandom);
      run(d, wr, ph, rg, wd, pr, rv, 1'b0, $sformatf("rand%0d", r), rd, er, w);
      expect_rsp(d, wr, pr, rv, rd, er, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
